// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: funct3 codes,
// FSM state encoding and the byte-enable width.
package lsu_pkg;

  localparam int BE_W = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-lane replication, legality and
// alignment flags for the request, plus load extraction/extension of the reply.
module lsu_align
  import lsu_pkg::*;
(
  input  logic            i_is_store,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  input  logic [31:0]     i_wdata,
  input  logic [2:0]      i_ld_funct3,
  input  logic [1:0]      i_ld_off,
  input  logic [31:0]     i_rdata,
  output logic [BE_W-1:0] o_be,
  output logic [31:0]     o_wdata,
  output logic [1:0]      o_off,
  output logic            o_illegal,
  output logic            o_misalign,
  output logic [31:0]     o_ldata
);

  function automatic logic [31:0] extend_load(input logic [2:0] f3,
                                              input logic [1:0] off,
                                              input logic [31:0] w);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] s;
    sh = w >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (f3)
      F3_B:    begin s = b; extend_load = s; end
      F3_H:    begin s = h; extend_load = s; end
      F3_BU:   extend_load = {24'd0, sh[7:0]};
      F3_HU:   extend_load = {16'd0, sh[15:0]};
      default: extend_load = w;
    endcase
  endfunction

  // Offsets are forced onto the natural boundary so a tolerated misaligned
  // access still hits a legal lane pattern.
  always_comb begin
    o_illegal  = 1'b0;
    o_misalign = 1'b0;
    o_off      = i_addr_lo;
    o_be       = '0;
    o_wdata    = i_wdata;
    case (i_funct3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << o_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_misalign = i_addr_lo[0];
        o_off      = {i_addr_lo[1], 1'b0};
        o_be       = 4'b0011 << o_off;
        o_wdata    = {2{i_wdata[15:0]}};
      end
      2'b10: begin
        o_misalign = |i_addr_lo;
        o_off      = 2'b00;
        o_be       = 4'b1111;
      end
      default: o_illegal = 1'b1;
    endcase
    if (i_funct3[2] && (i_is_store || i_funct3[1]))
      o_illegal = 1'b1;
  end

  assign o_ldata = extend_load(i_ld_funct3, i_ld_off, i_rdata);

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: IDLE/BUSY/DONE handshake FSM with timeout.
// Build option LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of aligning them.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [2:0]        InstrM,
  input  logic [31:0]       ALUResultM,
  input  logic [31:0]       WriteDataM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [BE_W-1:0]   dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ready,
  input  logic [31:0]       dmem_rdata,
  output logic [31:0]       ReadDataM,
  output logic              StallM,
  output logic              BusErrM
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  lsu_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_req, r_we, r_load, r_buserr;
  logic [ADDR_W-1:0] r_addr;
  logic [BE_W-1:0]   r_be;
  logic [31:0]       r_wdata, r_rdata;
  logic [2:0]        r_f3;
  logic [1:0]        r_off;

  logic              w_access, w_err, w_timeout;
  logic              w_illegal, w_misalign;
  logic [BE_W-1:0]   w_be;
  logic [31:0]       w_wdata, w_ldata;
  logic [1:0]        w_off;

  lsu_align u_align (
    .i_is_store (MemWriteM),
    .i_funct3   (InstrM),
    .i_addr_lo  (ALUResultM[1:0]),
    .i_wdata    (WriteDataM),
    .i_ld_funct3(r_f3),
    .i_ld_off   (r_off),
    .i_rdata    (dmem_rdata),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_off      (w_off),
    .o_illegal  (w_illegal),
    .o_misalign (w_misalign),
    .o_ldata    (w_ldata)
  );

  assign w_access = MemReadM | MemWriteM;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_err = (MemReadM & MemWriteM) | w_illegal | w_misalign;
`else
  logic w_misalign_unused;
  assign w_misalign_unused = w_misalign;
  assign w_err = (MemReadM & MemWriteM) | w_illegal;
`endif

  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

  // Stall covers the IDLE decode cycle and every BUSY cycle; DONE releases it.
  always_comb begin
    StallM = 1'b0;
    if (!reset) begin
      case (r_state)
        IDLE:    StallM = w_access;
        BUSY:    StallM = 1'b1;
        default: StallM = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_be     <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_buserr <= 1'b0;
      r_load   <= 1'b0;
      r_f3     <= '0;
      r_off    <= '0;
    end else begin
      r_buserr <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_access) begin
            if (w_err) begin
              r_rdata  <= '0;
              r_buserr <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_req   <= 1'b1;
              r_we    <= MemWriteM;
              r_addr  <= {ALUResultM[ADDR_W-1:2], 2'b00};
              r_be    <= w_be;
              r_wdata <= w_wdata;
              r_f3    <= InstrM;
              r_off   <= w_off;
              r_load  <= MemReadM;
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          // A completion in the same cycle as the timeout still counts.
          if (dmem_ready) begin
            r_req   <= 1'b0;
            if (r_load) r_rdata <= w_ldata;
            r_state <= DONE;
          end else if (w_timeout) begin
            r_req    <= 1'b0;
            r_buserr <= 1'b1;
            r_rdata  <= '0;
            r_state  <= DONE;
          end
        end
        DONE: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_be    = r_be;
  assign dmem_wdata = r_wdata;
  assign ReadDataM  = r_rdata;
  assign BusErrM    = r_buserr;

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit. It consumes the E/M pipeline register outputs (funct3, ALU address, store data) and drives a ready-handshake data-memory port.
- It generates byte enables, store-data lane placement and load sign/zero extension.
- It stalls the pipeline while an access is outstanding.
- It presents the aligned, extended load result to the M/W register.

Parameters:
- TIMEOUT_CYCLES, 255: max BUSY cycles before the access is abandoned; 0 disables the timeout.
- ADDR_W, 32: data address width.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- MemReadM  in  1  load in M stage
- MemWriteM  in  1  store in M stage
- InstrM  in  3  funct3 of the M-stage instruction
- ALUResultM  in  32  effective address
- WriteDataM  in  32  store data, unshifted
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_W  word-aligned address ({addr[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-shifted store data
- dmem_ready  in  1  memory completes the request this cycle
- dmem_rdata  in  32  read word, valid when dmem_ready=1
- ReadDataM  out  32  extended load result, to the M/W register
- StallM  out  1  freeze F/D/E/M registers
- BusErrM  out  1  one-cycle pulse: timeout or illegal/misaligned access

Behaviour:
- Reset values: state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0, ReadDataM=0, BusErrM=0, timeout counter=0. StallM=0 while reset is high.
- funct3 decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - All other codes are illegal.
- Misaligned access: halfword with addr[0]=1, or word with addr[1:0]!=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - No access (MemReadM=MemWriteM=0): StallM=0, stay in IDLE.
  - Legal, aligned access: StallM=1. Next cycle: dmem_req=1, with dmem_we/addr/be/wdata registered from the M-stage inputs; state moves to BUSY.
  - Illegal or misaligned access: no request issued. BusErrM pulses next cycle, ReadDataM=0, state moves to DONE.
- BUSY:
  - dmem_req and all dmem_* outputs stay stable. StallM=1. Counter increments each cycle.
  - dmem_ready=1: capture the extended load data (loads only) into ReadDataM. Drop dmem_req next cycle, go to DONE.
  - Counter reaches TIMEOUT_CYCLES (when nonzero) with dmem_ready=0: drop dmem_req, pulse BusErrM, ReadDataM=0, go to DONE.
  - dmem_ready and timeout in the same cycle: dmem_ready wins.
- DONE: StallM=0 for one cycle so the pipeline advances; ReadDataM holds its value. Next state is IDLE, counter cleared.
- Back-to-back accesses each pay IDLE→BUSY→DONE. Minimum M-stage residency with zero-wait memory (ready in the first BUSY cycle) is 3 cycles.
- Byte enables:
  - SB: be = 0001<<addr[1:0], wdata = {4{WriteDataM[7:0]}}.
  - SH: be = 0011<<addr[1:0], wdata = {2{WriteDataM[15:0]}}.
  - SW: be = 1111, wdata = WriteDataM.
  - Loads: be as for the corresponding store width, dmem_we=0.
- Load extract: select byte/halfword by addr[1:0], then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- MemReadM and MemWriteM both high is illegal; handle as BusErr.
- Inputs are sampled only in IDLE. M-stage inputs are held by the stall, so they are not re-sampled in BUSY.
- reset mid-access: immediate return to IDLE with dmem_req=0. Any in-flight dmem_ready is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned access is rejected as above (BusErrM, no request).
- Undefined: misaligned access is treated as aligned by forcing the low address bits to the natural boundary (halfword addr[0]=0, word addr[1:0]=00), and is performed normally with no BusErrM. Illegal funct3 still errors.

Decomposition:
- Package lsu_pkg:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state enum: IDLE, BUSY, DONE.
  - Byte-enable width constant.
- Sub-module lsu_align (combinational): from funct3 and addr[1:0], produces be, wdata lanes, load extract/extension and the misalign/illegal flags. FSM and counter live in mem_stage_lsu.

Test Plan:
- LW addr 0x100, memory returns 0xDEADBEEF on the first BUSY cycle → dmem_be=1111; ReadDataM=0xDEADBEEF in DONE; StallM high exactly 2 cycles.
- LB addr 0x103, rdata 0x80123456 → dmem_be=1000, ReadDataM=0xFFFFFF80. Same access as LBU → ReadDataM=0x00000080.
- SH addr 0x202, WriteDataM 0x0000ABCD → dmem_we=1, dmem_be=1100, dmem_wdata=0xABCDABCD; ReadDataM unchanged.
- LW addr 0x101:
  - with LSU_MISALIGN_TRAP_EN: no dmem_req, BusErrM one pulse, ReadDataM=0.
  - without: access issued to 0x100.
- TIMEOUT_CYCLES=4, dmem_ready held low → dmem_req high 4 BUSY cycles, then drops; BusErrM pulses; StallM releases in DONE.
- reset asserted during the 2nd BUSY cycle → next edge: dmem_req=0, state IDLE, StallM=0. A later dmem_ready has no effect.
